// File: rtl/me_scan_ctrl.sv
// rtl/me_scan_ctrl.sv - full-search scan controller for the motion-estimation processor
// Walks the search window row by row, issues RAM reads and tags each pixel shift with its candidate.
module me_scan_ctrl #(
   parameter int BLK   = 16,
   parameter int RANGE = 16,
   parameter int SW_W  = BLK + RANGE - 1,
   parameter int AW    = 10,
   parameter int CW    = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          mem_rdy,
   output logic          sw_rd,
   output logic [AW-1:0] sw_addr,
   output logic          sr_en,
   output logic          cand_valid,
   output logic [CW-1:0] cand_x,
   output logic [CW-1:0] cand_y,
   output logic          busy,
   output logic          done
);

   localparam int CLW = (SW_W > 1) ? $clog2(SW_W) : 1;
   localparam int RW  = (RANGE > 1) ? $clog2(RANGE) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [CLW-1:0]  col_q, col_d;
   logic [RW-1:0]   row_q, row_d;
   logic [AW-1:0]   base_q, base_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            sr_en_q, sr_en_d;
   logic            cand_valid_q, cand_valid_d;
   logic [CW-1:0]   cand_x_q, cand_x_d;
   logic [CW-1:0]   cand_y_q, cand_y_d;
   logic            done_q, done_d;
   logic            issue;
   logic [AW-1:0]   issue_addr;

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      base_d       = base_q;
      addr_d       = addr_q;
      cand_x_d     = cand_x_q;
      cand_y_d     = cand_y_q;
      done_d       = 1'b0;
      issue        = (state_q == SCAN) && mem_rdy;
      issue_addr   = base_q + AW'(col_q);
      sr_en_d      = issue;
      // the first BLK-1 shifts of each row only refill the chain
      cand_valid_d = issue && (col_q >= CLW'(BLK - 1));

      if (cand_valid_d) begin
         cand_x_d = CW'(col_q - CLW'(BLK - 1));
         cand_y_d = CW'(row_q);
      end

      case (state_q)
         IDLE: begin
            // done cycle still counts as busy, so a start there is dropped
            if (start && !done_q) begin
               state_d = SCAN;
               col_d   = '0;
               row_d   = '0;
               base_d  = '0;
            end
         end
         SCAN: begin
            if (mem_rdy) begin
               addr_d = issue_addr;
               if (col_q == CLW'(SW_W - 1)) begin
                  col_d  = '0;
                  row_d  = row_q + 1'b1;
                  base_d = base_q + AW'(SW_W);
                  if (row_q == RW'(RANGE - 1)) state_d = DRAIN;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         col_q        <= '0;
         row_q        <= '0;
         base_q       <= '0;
         addr_q       <= '0;
         sr_en_q      <= 1'b0;
         cand_valid_q <= 1'b0;
         cand_x_q     <= '0;
         cand_y_q     <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         base_q       <= base_d;
         addr_q       <= addr_d;
         sr_en_q      <= sr_en_d;
         cand_valid_q <= cand_valid_d;
         cand_x_q     <= cand_x_d;
         cand_y_q     <= cand_y_d;
         done_q       <= done_d;
      end
   end

   assign sw_rd      = issue;
   assign sw_addr    = issue ? issue_addr : addr_q;
   assign sr_en      = sr_en_q;
   assign cand_valid = cand_valid_q;
   assign cand_x     = cand_x_q;
   assign cand_y     = cand_y_q;
   assign busy       = (state_q != IDLE) || done_q;
   assign done       = done_q;

endmodule
